audio_codec_i2s_master: RTL and testbench
=========================================

Name: audio_codec_i2s_master

Overview:
- Codec-side end of the WM8731 digital audio link: acts as bus master, generating BCLK, ADCLRCK and DACLRCK from the system clock.
- Serializes parallel ADC samples onto ADCDAT and deserializes DACDAT into parallel DAC samples.
- Drives the FPGA audio core's external interface in simulation and on loopback builds.
- Uses I2S (Philips) framing: LRCK low = left channel, MSB one BCLK after each LRCK edge.

Parameters:
BCLK_HALF_DIV, 8, clk cycles per BCLK half-period (>=2)
DATA_WIDTH, 24, sample bits per channel
SLOT_WIDTH, 32, BCLK cycles per channel slot (>= DATA_WIDTH+1)

Ports:
clk_clk  input  1  system clock
reset_reset_n  input  1  asynchronous active-low reset
enable  input  1  run link; deassertion stops at next frame boundary
adc_left  input  DATA_WIDTH  left sample to transmit
adc_right  input  DATA_WIDTH  right sample to transmit
adc_valid  input  1  sample pair offered
adc_ready  output  1  holding register empty
adc_underrun  output  1  1-cycle pulse: frame started with no sample held
dac_left  output  DATA_WIDTH  last received left sample
dac_right  output  DATA_WIDTH  last received right sample
dac_valid  output  1  1-cycle pulse: new dac pair
BCLK  output  1  bit clock
ADCLRCK  output  1  ADC frame clock
DACLRCK  output  1  DAC frame clock (identical to ADCLRCK)
ADCDAT  output  1  serial ADC data
DACDAT  input  1  serial DAC data

Behaviour:
- Reset: BCLK, ADCLRCK, DACLRCK, ADCDAT, adc_underrun, dac_valid = 0; dac_left/right = 0; adc_ready = 1; div_cnt = 0; bit_cnt = 0; state IDLE.
- States:
  - IDLE: BCLK low, counters at 0. Goes to RUN when enable = 1; the first BCLK rise comes BCLK_HALF_DIV cycles later.
  - RUN: div_cnt counts 0..BCLK_HALF_DIV-1; at terminal count BCLK toggles.
    - rise_evt = toggle 0->1. fall_evt = toggle 1->0.
    - bit_cnt (0..2*SLOT_WIDTH-1) increments on fall_evt and wraps to 0. The wrap is frame start.
    - If enable = 0 at frame start, go to IDLE with BCLK low and bit_cnt 0. A partial frame is never truncated.
- LRCK = (bit_cnt >= SLOT_WIDTH), registered, changes on fall_evt. Slot index k = bit_cnt mod SLOT_WIDTH.
- ADCDAT update: changes only on fall_evt.
  - k=0: 0.
  - k=1..DATA_WIDTH: bit DATA_WIDTH-k of the current channel (MSB first).
  - k>DATA_WIDTH: 0.
- Tx handshake:
  - adc_ready = !hold_full. Transfer when adc_valid & adc_ready on a clk edge.
  - At frame start, if hold_full: shift regs load the hold pair and hold_full clears. Otherwise: shift regs load zeros and adc_underrun pulses 1 cycle.
  - A transfer in the frame-start cycle with an empty hold goes to the hold register for the next frame; the current frame still underruns.
  - adc_valid may drop without transfer; no state changes.
- Rx: DACDAT is sampled on rise_evt for k=1..DATA_WIDTH into the channel shift reg, MSB first; other k are ignored.
  - On rise_evt at bit_cnt = 2*SLOT_WIDTH-1, dac_left/dac_right update and dac_valid pulses, both on the next clk cycle.
  - Outputs hold until the next frame.
- Async reset mid-frame: immediate return to reset values. Partial Rx data is discarded (no dac_valid).
- Widths: div_cnt = clog2(BCLK_HALF_DIV), bit_cnt = clog2(2*SLOT_WIDTH). No arithmetic overflow beyond the defined wraps.

Optional Feature:
AUDIO_CODEC_LOOPBACK_EN
- Defined: the Rx path samples the internal ADCDAT register instead of the DACDAT pin. DACDAT is ignored. A frame's transmitted pair reappears on dac_left/dac_right at that frame's dac_valid.
- Undefined: Rx samples the DACDAT pin as specified above.

Test Plan:
- Reset, then release with enable=0: all outputs 0, adc_ready=1, BCLK static for 1000 cycles.
- BCLK_HALF_DIV=2, SLOT_WIDTH=32, enable=1: BCLK period is 4 clk. LRCK toggles every 32 BCLK falls (128 clk). Frame is 256 clk. ADCLRCK == DACLRCK always.
- Offer left=0xA5A5A5, right=0x123456 before the frame: adc_ready drops and rises at frame start. ADCDAT slot bits 1..24 read 0xA5A5A5 then 0x123456 MSB first; bits 0 and 25..31 are 0.
- Bench drives DACDAT with left=0xFEDCBA, right=0x000001 in I2S format: one dac_valid pulse after the frame's final BCLK rise, with dac_left=0xFEDCBA and dac_right=0x000001.
- adc_valid held 0: each frame start gives one adc_underrun pulse and ADCDAT stays 0. enable dropped at bit_cnt=10: frame completes, IDLE at bit_cnt=0, BCLK low.
- With AUDIO_CODEC_LOOPBACK_EN, offer 0x000001/0x800000: dac_valid returns 0x000001/0x800000 with DACDAT tied to 1.

Source files
------------

// File: rtl/audio_codec_i2s_master.sv
// WM8731-style I2S bus master: generates BCLK/LRCK, serializes ADC pairs, deserializes DAC pairs.
// Build option: define AUDIO_CODEC_LOOPBACK_EN to feed the receiver from the internal ADCDAT register.
module audio_codec_i2s_master #(
  parameter int BCLK_HALF_DIV = 8,
  parameter int DATA_WIDTH    = 24,
  parameter int SLOT_WIDTH    = 32
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] adc_left,
  input  logic [DATA_WIDTH-1:0] adc_right,
  input  logic                  adc_valid,
  output logic                  adc_ready,
  output logic                  adc_underrun,
  output logic [DATA_WIDTH-1:0] dac_left,
  output logic [DATA_WIDTH-1:0] dac_right,
  output logic                  dac_valid,
  output logic                  BCLK,
  output logic                  ADCLRCK,
  output logic                  DACLRCK,
  output logic                  ADCDAT,
  input  logic                  DACDAT
);

  localparam int DIV_W = $clog2(BCLK_HALF_DIV);
  localparam int BIT_W = $clog2(2 * SLOT_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_WIDTH - 1);
  localparam logic [BIT_W-1:0] SLOT_V   = BIT_W'(SLOT_WIDTH);
  localparam logic [BIT_W-1:0] DATA_V   = BIT_W'(DATA_WIDTH);
  localparam logic [BIT_W-1:0] ONE_V    = BIT_W'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state_reg, state_next;
  logic [DIV_W-1:0]       div_cnt_reg;
  logic [BIT_W-1:0]       bit_cnt_reg, bit_cnt_next;
  logic                   bclk_reg, lrck_reg, adcdat_reg;
  logic                   hold_full_reg, underrun_reg, dac_valid_reg;
  logic [DATA_WIDTH-1:0]  hold_left_reg, hold_right_reg;
  logic [DATA_WIDTH-1:0]  tx_left_reg, tx_right_reg;
  logic [DATA_WIDTH-1:0]  rx_left_reg, rx_right_reg, rx_left_next, rx_right_next;
  logic [DATA_WIDTH-1:0]  dac_left_reg, dac_right_reg;

  logic tc, rise_evt, fall_evt, frame_end, frame_start, xfer, rx_bit;
  logic [BIT_W-1:0] cur_k, nxt_k;
  logic cur_data, nxt_data, cur_right, nxt_right;

  function automatic logic [BIT_W-1:0] slot_idx(input logic [BIT_W-1:0] b);
    return (b >= SLOT_V) ? (b - SLOT_V) : b;
  endfunction

  assign tc           = (state_reg == RUN) && (div_cnt_reg == DIV_LAST);
  assign rise_evt     = tc && !bclk_reg;
  assign fall_evt     = tc && bclk_reg;
  assign frame_end    = (bit_cnt_reg == BIT_LAST);
  assign bit_cnt_next = frame_end ? '0 : bit_cnt_reg + 1'b1;
  assign cur_k        = slot_idx(bit_cnt_reg);
  assign nxt_k        = slot_idx(bit_cnt_next);
  assign cur_data     = (cur_k >= ONE_V) && (cur_k <= DATA_V);
  assign nxt_data     = (nxt_k >= ONE_V) && (nxt_k <= DATA_V);
  assign cur_right    = (bit_cnt_reg >= SLOT_V);
  assign nxt_right    = (bit_cnt_next >= SLOT_V);
  assign xfer         = adc_valid && !hold_full_reg;

`ifdef AUDIO_CODEC_LOOPBACK_EN
  assign rx_bit = adcdat_reg;
`else
  assign rx_bit = DACDAT;
`endif

  // A frame starts on leaving IDLE and on every bit counter wrap while enabled.
  always_comb begin
    state_next  = state_reg;
    frame_start = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enable) begin
          state_next  = RUN;
          frame_start = 1'b1;
        end
      end
      RUN: begin
        if (fall_evt && frame_end) begin
          if (enable) frame_start = 1'b1;
          else        state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state_reg <= IDLE;
    else                state_reg <= state_next;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      div_cnt_reg <= '0;
      bclk_reg    <= 1'b0;
      bit_cnt_reg <= '0;
      lrck_reg    <= 1'b0;
      adcdat_reg  <= 1'b0;
    end else begin
      if (state_reg == RUN) div_cnt_reg <= tc ? '0 : div_cnt_reg + 1'b1;
      if (tc) bclk_reg <= !bclk_reg;
      if (fall_evt) begin
        bit_cnt_reg <= bit_cnt_next;
        lrck_reg    <= nxt_right;
        adcdat_reg  <= nxt_data ? (nxt_right ? tx_right_reg[DATA_WIDTH-1]
                                             : tx_left_reg[DATA_WIDTH-1]) : 1'b0;
      end
    end
  end

  // Transmit path: one-deep holding register, reloaded into the shifters at frame start.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      hold_full_reg  <= 1'b0;
      hold_left_reg  <= '0;
      hold_right_reg <= '0;
      tx_left_reg    <= '0;
      tx_right_reg   <= '0;
      underrun_reg   <= 1'b0;
    end else begin
      underrun_reg  <= 1'b0;
      hold_full_reg <= xfer || (hold_full_reg && !frame_start);
      if (xfer) begin
        hold_left_reg  <= adc_left;
        hold_right_reg <= adc_right;
      end
      if (frame_start) begin
        if (hold_full_reg) begin
          tx_left_reg  <= hold_left_reg;
          tx_right_reg <= hold_right_reg;
        end else begin
          tx_left_reg  <= '0;
          tx_right_reg <= '0;
          underrun_reg <= 1'b1;
        end
      end else if (fall_evt && nxt_data) begin
        if (nxt_right) tx_right_reg <= tx_right_reg << 1;
        else           tx_left_reg  <= tx_left_reg << 1;
      end
    end
  end

  // Next-state shifters also cover SLOT_WIDTH = DATA_WIDTH+1, where the last data bit and the latch coincide.
  always_comb begin
    rx_left_next  = rx_left_reg;
    rx_right_next = rx_right_reg;
    if (rise_evt && cur_data) begin
      if (cur_right) rx_right_next = {rx_right_reg[DATA_WIDTH-2:0], rx_bit};
      else           rx_left_next  = {rx_left_reg[DATA_WIDTH-2:0], rx_bit};
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rx_left_reg   <= '0;
      rx_right_reg  <= '0;
      dac_left_reg  <= '0;
      dac_right_reg <= '0;
      dac_valid_reg <= 1'b0;
    end else begin
      dac_valid_reg <= 1'b0;
      rx_left_reg   <= rx_left_next;
      rx_right_reg  <= rx_right_next;
      if (rise_evt && frame_end) begin
        dac_left_reg  <= rx_left_next;
        dac_right_reg <= rx_right_next;
        dac_valid_reg <= 1'b1;
      end
    end
  end

  assign adc_ready    = !hold_full_reg;
  assign adc_underrun = underrun_reg;
  assign dac_left     = dac_left_reg;
  assign dac_right    = dac_right_reg;
  assign dac_valid    = dac_valid_reg;
  assign BCLK         = bclk_reg;
  assign ADCLRCK      = lrck_reg;
  assign DACLRCK      = lrck_reg;
  assign ADCDAT       = adcdat_reg;

endmodule

// File: tb/tb_audio_codec_i2s_master.sv
// Scoreboard bench for audio_codec_i2s_master: bus monitor/driver, dac_valid monitor, directed stimulus.
module tb_audio_codec_i2s_master;
  localparam int HALF = 2;
  localparam int DW   = 24;
  localparam int SW   = 32;

  logic clk_clk = 1'b0;
  logic reset_reset_n, enable, adc_valid, DACDAT;
  logic [DW-1:0] adc_left, adc_right, dac_left, dac_right;
  logic adc_ready, adc_underrun, dac_valid, BCLK, ADCLRCK, DACLRCK, ADCDAT;

  always #5 clk_clk = ~clk_clk;

  audio_codec_i2s_master #(.BCLK_HALF_DIV(HALF), .DATA_WIDTH(DW), .SLOT_WIDTH(SW)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .enable(enable),
    .adc_left(adc_left), .adc_right(adc_right), .adc_valid(adc_valid),
    .adc_ready(adc_ready), .adc_underrun(adc_underrun),
    .dac_left(dac_left), .dac_right(dac_right), .dac_valid(dac_valid),
    .BCLK(BCLK), .ADCLRCK(ADCLRCK), .DACLRCK(DACLRCK), .ADCDAT(ADCDAT), .DACDAT(DACDAT)
  );

  typedef struct packed {logic [DW-1:0] l; logic [DW-1:0] r;} pair_t;

  pair_t exp_adc_q[$];
  pair_t drive_q[$];
  pair_t exp_dac_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus monitor / DACDAT driver: tracks the frame position from BCLK edges.
  int    b = 0;
  int    mk;
  int    gap = 0;
  int    ur_cnt = 0;
  int    frames_done = 0;
  int    rises = 0;
  logic  bclk_prev = 1'b0;
  logic  extra;
  logic  exp_ur;
  pair_t cur_tx, cur_drive;
  logic [DW-1:0] cap_l, cap_r;

  always @(negedge clk_clk) begin
    if (!reset_reset_n) begin
      b = 0; gap = 0; ur_cnt = 0; bclk_prev = 1'b0;
    end else begin
      gap++;
      if (adc_underrun) ur_cnt++;
      if (BCLK && !bclk_prev) begin
        rises++;
        if (b != 0) check("bclk_period", 64'(gap), 64'(2 * HALF));
        gap = 0;
        if (b == 0) begin
          exp_ur = (exp_adc_q.size() == 0);
          check("underrun_pulses", 64'(ur_cnt), 64'(exp_ur));
          ur_cnt    = 0;
          cur_tx    = exp_ur ? '0 : exp_adc_q.pop_front();
          cur_drive = (drive_q.size() != 0) ? drive_q.pop_front() : '0;
`ifdef AUDIO_CODEC_LOOPBACK_EN
          exp_dac_q.push_back(cur_tx);
`else
          exp_dac_q.push_back(cur_drive);
`endif
          cap_l = '0; cap_r = '0; extra = 1'b0;
        end
        check("lrck", {62'd0, DACLRCK, ADCLRCK}, (b >= SW) ? 64'd3 : 64'd0);
        mk = b % SW;
        if (mk >= 1 && mk <= DW) begin
          if (b >= SW) cap_r = {cap_r[DW-2:0], ADCDAT};
          else         cap_l = {cap_l[DW-2:0], ADCDAT};
        end else begin
          extra = extra | ADCDAT;
        end
        if (b == 2 * SW - 1) begin
          check("adcdat_left", 64'(cap_l), 64'(cur_tx.l));
          check("adcdat_right", 64'(cap_r), 64'(cur_tx.r));
          check("adcdat_pad_bits", 64'(extra), 64'd0);
          $display("frame %0d: ADCDAT left=0x%06h right=0x%06h", frames_done, cap_l, cap_r);
          frames_done++;
        end
      end else if (!BCLK && bclk_prev) begin
        b  = (b == 2 * SW - 1) ? 0 : b + 1;
        mk = b % SW;
`ifdef AUDIO_CODEC_LOOPBACK_EN
        DACDAT = 1'b1;
`else
        if (mk >= 1 && mk <= DW) DACDAT = (b >= SW) ? cur_drive.r[DW-mk] : cur_drive.l[DW-mk];
        else                     DACDAT = 1'b1;
`endif
      end
      bclk_prev = BCLK;
    end
  end

  // dac_valid monitor
  int    dv_cnt = 0;
  pair_t exp_dac;
  always @(negedge clk_clk) begin
    if (reset_reset_n && dac_valid) begin
      dv_cnt++;
      check("dac_valid_timing", {62'd0, BCLK, (b == 2 * SW - 1)}, 64'd3);
      if (exp_dac_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL dac_unexpected: got dac_valid with no expected pair");
      end else begin
        exp_dac = exp_dac_q.pop_front();
        check("dac_left", 64'(dac_left), 64'(exp_dac.l));
        check("dac_right", 64'(dac_right), 64'(exp_dac.r));
      end
      $display("dac_valid: left=0x%06h right=0x%06h", dac_left, dac_right);
    end
  end

  task automatic offer(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int t;
    t = 0;
    @(negedge clk_clk);
    while (!adc_ready && t < 1000) begin @(negedge clk_clk); t++; end
    check("offer_ready_wait", 64'(adc_ready), 64'd1);
    adc_left = l; adc_right = r; adc_valid = 1'b1;
    exp_adc_q.push_back('{l, r});
    $display("offer: left=0x%06h right=0x%06h", l, r);
    @(negedge clk_clk);
    adc_valid = 1'b0;
    check("ready_after_offer", 64'(adc_ready), 64'd0);
  endtask

  task automatic wait_pos(input int f, input int bit_pos, input int budget);
    int t;
    t = 0;
    while (!(frames_done == f && b == bit_pos) && t < budget) begin @(negedge clk_clk); t++; end
    check("wait_position", {32'(frames_done), 32'(b)}, {32'(f), 32'(bit_pos)});
  endtask

  int rises_snap;

  initial begin
    reset_reset_n = 1'b0; enable = 1'b0; adc_valid = 1'b0;
    adc_left = '0; adc_right = '0; DACDAT = 1'b1;
    repeat (3) @(negedge clk_clk);
    check("reset_outs", {57'd0, BCLK, ADCLRCK, DACLRCK, ADCDAT, adc_underrun, dac_valid, adc_ready}, 64'd1);
    check("reset_dac", {16'd0, dac_left, dac_right}, 64'd0);
    reset_reset_n = 1'b1;
    repeat (1000) @(negedge clk_clk);
    check("idle_bclk_static", 64'(rises), 64'd0);
    check("idle_outs", {57'd0, BCLK, ADCLRCK, DACLRCK, ADCDAT, adc_underrun, dac_valid, adc_ready}, 64'd1);
    check("idle_dac", {16'd0, dac_left, dac_right}, 64'd0);

    offer(24'hA5A5A5, 24'h123456);
    drive_q.push_back('{24'hFEDCBA, 24'h000001});
    enable = 1'b1;
    repeat (5) @(negedge clk_clk);
    check("ready_after_frame_start", 64'(adc_ready), 64'd1);

    offer(24'h000001, 24'h800000);
    drive_q.push_back('{24'h800000, 24'h7FFFFF});
    // Offer while full, then withdraw: must not replace the held pair.
    adc_left = 24'hDEADBE; adc_right = 24'hEFCAFE; adc_valid = 1'b1;
    repeat (3) @(negedge clk_clk);
    adc_valid = 1'b0;
    check("ready_while_full", 64'(adc_ready), 64'd0);

    wait_pos(3, 10, 2000);
    enable = 1'b0;
    wait_pos(4, 0, 1000);
    repeat (10) @(negedge clk_clk);
    rises_snap = rises;
    repeat (300) @(negedge clk_clk);
    check("stopped_no_rises", 64'(rises - rises_snap), 64'd0);
    check("stopped_lines", {61'd0, BCLK, ADCLRCK, ADCDAT}, 64'd0);
    check("stopped_frames", 64'(frames_done), 64'd4);
    check("dac_valid_count", 64'(dv_cnt), 64'd4);
    check("dac_queue_empty", 64'(exp_dac_q.size()), 64'd0);
    check("adc_queue_empty", 64'(exp_adc_q.size()), 64'd0);
    check("no_stray_underrun", 64'(ur_cnt), 64'd0);
    check("final_ready", 64'(adc_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
